// File: rtl/uart_byte_link.sv
// 8N1 LSB-first UART link: synchronised receiver with armed/one-byte-buffer
// delivery toward the decoder, plus a single-shot transmitter.
module uart_byte_link #(
    parameter int CLK_DIV = 434
) (
    input  logic       in_clk,
    input  logic       in_rst,
    input  logic       in_rxd,
    output logic       out_txd,
    output logic [7:0] data_rx,
    output logic       rx_done,
    input  logic       rx_trig,
    input  logic [7:0] data_tx,
    input  logic       tx_trig,
    output logic       tx_done,
    output logic       out_tx_busy,
    output logic       out_rx_overrun,
    output logic       out_rx_frame_err
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txState_t;

    logic          rxdMeta_q, rxdSync_q;
    rxState_t      rxState_q;
    logic [CW-1:0] rxCnt_q;
    logic [2:0]    rxBit_q;
    logic [7:0]    rxShift_q;
    logic          frameErr_q;
    logic          rxSample, rxByteDone;

    logic       armed_q, armed_d;
    logic       bufFull_q, bufFull_d;
    logic [7:0] buf_q, buf_d;
    logic [7:0] dataRx_q, dataRx_d;
    logic       rxDone_q, rxDone_d;
    logic       overrun_q, overrun_d;

    txState_t      txState_q;
    logic [CW-1:0] txCnt_q;
    logic [2:0]    txBit_q;
    logic [7:0]    txShift_q;
    logic          txd_q, busy_q, txDone_q;

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            rxdMeta_q <= 1'b1;
            rxdSync_q <= 1'b1;
        end else begin
            rxdMeta_q <= in_rxd;
            rxdSync_q <= rxdMeta_q;
        end
    end

    assign rxSample   = (rxCnt_q == '0);
    assign rxByteDone = (rxState_q == RX_STOP) && rxSample && rxdSync_q;

    // Counter runs down; every bit decision is taken when it reaches zero.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            rxState_q  <= RX_IDLE;
            rxCnt_q    <= '0;
            rxBit_q    <= '0;
            rxShift_q  <= '0;
            frameErr_q <= 1'b0;
        end else begin
            case (rxState_q)
                RX_IDLE: begin
                    if (!rxdSync_q) begin
                        rxState_q <= RX_START;
                        rxCnt_q   <= HALF_LAST;
                    end
                end
                RX_START: begin
                    if (!rxSample) begin
                        rxCnt_q <= rxCnt_q - 1'b1;
                    end else if (rxdSync_q) begin
                        rxState_q <= RX_IDLE;
                    end else begin
                        rxState_q <= RX_DATA;
                        rxCnt_q   <= BIT_LAST;
                        rxBit_q   <= '0;
                    end
                end
                RX_DATA: begin
                    if (!rxSample) begin
                        rxCnt_q <= rxCnt_q - 1'b1;
                    end else begin
                        rxShift_q <= {rxdSync_q, rxShift_q[7:1]};
                        rxCnt_q   <= BIT_LAST;
                        rxBit_q   <= rxBit_q + 3'd1;
                        if (rxBit_q == 3'd7) begin
                            rxState_q <= RX_STOP;
                        end
                    end
                end
                RX_STOP: begin
                    if (!rxSample) begin
                        rxCnt_q <= rxCnt_q - 1'b1;
                    end else begin
                        rxState_q <= RX_IDLE;
                        if (!rxdSync_q) begin
                            frameErr_q <= 1'b1;
                        end
                    end
                end
                default: rxState_q <= RX_IDLE;
            endcase
        end
    end

    // A trigger is resolved before a byte completing in the same cycle.
    always_comb begin
        armed_d   = armed_q;
        bufFull_d = bufFull_q;
        buf_d     = buf_q;
        dataRx_d  = dataRx_q;
        rxDone_d  = 1'b0;
        overrun_d = overrun_q;
        if (rx_trig) begin
            if (bufFull_q) begin
                dataRx_d  = buf_q;
                rxDone_d  = 1'b1;
                bufFull_d = 1'b0;
            end else begin
                armed_d = 1'b1;
            end
        end
        if (rxByteDone) begin
            if (armed_d) begin
                dataRx_d = rxShift_q;
                rxDone_d = 1'b1;
                armed_d  = 1'b0;
            end else if (!bufFull_d) begin
                buf_d     = rxShift_q;
                bufFull_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            armed_q   <= 1'b1;
            bufFull_q <= 1'b0;
            buf_q     <= '0;
            dataRx_q  <= '0;
            rxDone_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            armed_q   <= armed_d;
            bufFull_q <= bufFull_d;
            buf_q     <= buf_d;
            dataRx_q  <= dataRx_d;
            rxDone_q  <= rxDone_d;
            overrun_q <= overrun_d;
        end
    end

    // Line level is registered one state ahead so out_txd changes on the
    // same edge the state does.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            txState_q <= TX_IDLE;
            txCnt_q   <= '0;
            txBit_q   <= '0;
            txShift_q <= '0;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
            txDone_q  <= 1'b0;
        end else begin
            txDone_q <= 1'b0;
            case (txState_q)
                TX_IDLE: begin
                    if (tx_trig) begin
                        txState_q <= TX_START;
                        txShift_q <= data_tx;
                        txCnt_q   <= BIT_LAST;
                        txd_q     <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                TX_START: begin
                    if (txCnt_q != '0) begin
                        txCnt_q <= txCnt_q - 1'b1;
                    end else begin
                        txState_q <= TX_DATA;
                        txCnt_q   <= BIT_LAST;
                        txBit_q   <= '0;
                        txd_q     <= txShift_q[0];
                    end
                end
                TX_DATA: begin
                    if (txCnt_q != '0) begin
                        txCnt_q <= txCnt_q - 1'b1;
                    end else begin
                        txCnt_q <= BIT_LAST;
                        if (txBit_q == 3'd7) begin
                            txState_q <= TX_STOP;
                            txd_q     <= 1'b1;
                        end else begin
                            txd_q     <= txShift_q[1];
                            txShift_q <= {1'b0, txShift_q[7:1]};
                            txBit_q   <= txBit_q + 3'd1;
                        end
                    end
                end
                TX_STOP: begin
                    if (txCnt_q != '0) begin
                        txCnt_q <= txCnt_q - 1'b1;
                    end else begin
                        txState_q <= TX_IDLE;
                        busy_q    <= 1'b0;
                        txDone_q  <= 1'b1;
                    end
                end
                default: txState_q <= TX_IDLE;
            endcase
        end
    end

    assign out_txd          = txd_q;
    assign out_tx_busy      = busy_q;
    assign tx_done          = txDone_q;
    assign data_rx          = dataRx_q;
    assign rx_done          = rxDone_q;
    assign out_rx_overrun   = overrun_q;
    assign out_rx_frame_err = frameErr_q;

endmodule
